// File: rtl/bus_grant_arbiter.sv
// Round-robin owner select for the shared 32-bit internal bus, with a one-cycle gap between owners.
// Define ARB_TIMEOUT_EN to compile in forced release after MAX_HOLD granted cycles.
module bus_grant_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] req,
  output logic [31:0] gnt,
  output logic [4:0]  gnt_id,
  output logic        gnt_valid,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [4:0] NO_OWNER = 5'b11111;

  state_t      state_reg;
  logic [4:0]  ptr_reg;
  logic [31:0] gnt_reg;
  logic [4:0]  gnt_id_reg;
  logic        gnt_valid_reg;

  logic [31:0] req_rot;
  logic [4:0]  win_off;
  logic [4:0]  win_id;
  logic        win_found;
  logic        owner_req;

  generate
    if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
      $error("bus_grant_arbiter: MAX_HOLD must lie in 2..256");
    end
  endgenerate

  // Rotate requests so bit 0 is the driver the pointer names; 5-bit index wraps 31 -> 0.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rot
      assign req_rot[gi] = req[ptr_reg + 5'(gi)];
    end
  endgenerate

  always_comb begin
    win_found = 1'b0;
    win_off   = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_found = 1'b1;
        win_off   = 5'(i);
      end
    end
  end

  assign win_id    = ptr_reg + win_off;
  assign owner_req = |(req & gnt_reg);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_reg;
  logic       timeout_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg     <= IDLE;
      ptr_reg       <= 5'd0;
      gnt_reg       <= 32'd0;
      gnt_id_reg    <= NO_OWNER;
      gnt_valid_reg <= 1'b0;
      hold_reg      <= 8'd0;
      timeout_reg   <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE, GAP: begin
          if (win_found) begin
            state_reg     <= GRANT;
            gnt_reg       <= 32'd1 << win_id;
            gnt_id_reg    <= win_id;
            gnt_valid_reg <= 1'b1;
            ptr_reg       <= win_id + 5'd1;
            hold_reg      <= 8'd0;
          end else begin
            state_reg <= IDLE;
          end
        end
        GRANT: begin
          if (!owner_req || hold_reg == HOLD_LAST) begin
            state_reg     <= GAP;
            gnt_reg       <= 32'd0;
            gnt_id_reg    <= NO_OWNER;
            gnt_valid_reg <= 1'b0;
            // Only a release the owner did not ask for counts as a timeout.
            timeout_reg   <= owner_req;
          end else begin
            hold_reg <= hold_reg + 8'd1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          gnt_reg       <= 32'd0;
          gnt_id_reg    <= NO_OWNER;
          gnt_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign timeout = timeout_reg;
`else
  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg     <= IDLE;
      ptr_reg       <= 5'd0;
      gnt_reg       <= 32'd0;
      gnt_id_reg    <= NO_OWNER;
      gnt_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, GAP: begin
          if (win_found) begin
            state_reg     <= GRANT;
            gnt_reg       <= 32'd1 << win_id;
            gnt_id_reg    <= win_id;
            gnt_valid_reg <= 1'b1;
            ptr_reg       <= win_id + 5'd1;
          end else begin
            state_reg <= IDLE;
          end
        end
        GRANT: begin
          // Owner keeps the bus as long as it asks; other requests never preempt it.
          if (!owner_req) begin
            state_reg     <= GAP;
            gnt_reg       <= 32'd0;
            gnt_id_reg    <= NO_OWNER;
            gnt_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          gnt_reg       <= 32'd0;
          gnt_id_reg    <= NO_OWNER;
          gnt_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign timeout = 1'b0;
`endif

  assign gnt       = gnt_reg;
  assign gnt_id    = gnt_id_reg;
  assign gnt_valid = gnt_valid_reg;

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Self-checking bench for bus_grant_arbiter: directed scenarios plus randomized traffic against an owner/pointer model.
module tb_bus_grant_arbiter;

  localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] req = 32'd0;
  logic [31:0] gnt;
  logic [4:0]  gnt_id;
  logic        gnt_valid;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the bus, where the search starts, cycles owned so far.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  always #5 clk = ~clk;

  bus_grant_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .clr       (clr),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  function automatic logic [37:0] own(input int k);
    logic [37:0] r;
    if (k < 0) r = {32'd0, 5'h1f, 1'b0};
    else       r = {32'd1 << k, 5'(k), 1'b1};
    return r;
  endfunction

  task automatic model_step();
    bit found;
    m_to = 1'b0;
    if (clr) begin
      m_owner = -1; m_ptr = 0; m_held = 0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_owner = -1;
      end else if (TO_ON && m_held == MAX_HOLD) begin
        m_owner = -1; m_to = 1'b1;
      end else begin
        m_held++;
      end
    end else begin
      found = 1'b0;
      for (int d = 0; d < 32; d++) begin
        if (!found && req[(m_ptr + d) % 32]) begin
          found   = 1'b1;
          m_owner = (m_ptr + d) % 32;
        end
      end
      if (found) begin
        m_ptr  = (m_owner + 1) % 32;
        m_held = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1; req = 32'd0;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; req = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({gnt, gnt_id, gnt_valid} !== own(-1)) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d: got %h want %h", i, {gnt, gnt_id, gnt_valid}, own(-1));
      end
    end
    clr = 1'b0;
    tick();
    n_checks++;
    if ({gnt, gnt_id, gnt_valid} !== own(0)) begin
      n_fail++;
      $display("FAIL reset_release: got %h want %h", {gnt, gnt_id, gnt_valid}, own(0));
    end
    $display("reset: released, gnt=%h id=%0d", gnt, gnt_id);
  endtask

  task automatic test_single();
    do_reset();
    req = 32'h0000_0400;
    tick();
    n_checks++;
    if ({gnt, gnt_id, gnt_valid} !== own(10)) begin
      n_fail++;
      $display("FAIL single_grant: got %h want %h", {gnt, gnt_id, gnt_valid}, own(10));
    end
    req = 32'd0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({gnt, gnt_id, gnt_valid, timeout} !== {own(-1), 1'b0}) begin
        n_fail++;
        $display("FAIL single_release cyc=%0d: got %h want %h", i, {gnt, gnt_id, gnt_valid, timeout}, {own(-1), 1'b0});
      end
    end
    $display("single: owner 10 granted and released");
  endtask

  task automatic test_rotation();
    int order [4] = '{0, 1, 31, 0};
    logic [31:0] base;
    base = 32'h8000_0003;
    do_reset();
    req = base;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({gnt, gnt_id, gnt_valid} !== own(order[i])) begin
        n_fail++;
        $display("FAIL rotation_owner step=%0d: got %h want %h", i, {gnt, gnt_id, gnt_valid}, own(order[i]));
      end
      $display("rotation: step %0d owner id=%0d", i, gnt_id);
      if (i < 3) begin
        req = base & ~(32'd1 << order[i]);
        tick();
        n_checks++;
        if ({gnt, gnt_id, gnt_valid} !== own(-1)) begin
          n_fail++;
          $display("FAIL rotation_gap step=%0d: got %h want %h", i, {gnt, gnt_id, gnt_valid}, own(-1));
        end
        req = base;
        tick();
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 32'h4000_0000;
    tick();
    req = 32'd0;
    tick();
    req = 32'h8000_0001;
    tick();
    n_checks++;
    if ({gnt, gnt_id, gnt_valid} !== {32'h8000_0000, 5'b11111, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_owner31: got %h want %h", {gnt, gnt_id, gnt_valid}, {32'h8000_0000, 5'b11111, 1'b1});
    end
    req = 32'h0000_0001;
    tick();
    tick();
    n_checks++;
    if ({gnt, gnt_id, gnt_valid} !== own(0)) begin
      n_fail++;
      $display("FAIL wrap_next0: got %h want %h", {gnt, gnt_id, gnt_valid}, own(0));
    end
    $display("wrap: owner 31 then owner %0d", gnt_id);
  endtask

  task automatic test_no_preempt_reset();
    do_reset();
    req = 32'h0000_0020;
    tick();
    req = 32'h0000_0024;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({gnt, gnt_id, gnt_valid} !== own(5)) begin
        n_fail++;
        $display("FAIL no_preempt cyc=%0d: got %h want %h", i, {gnt, gnt_id, gnt_valid}, own(5));
      end
    end
    clr = 1'b1;
    tick();
    n_checks++;
    if ({gnt, gnt_id, gnt_valid} !== own(-1)) begin
      n_fail++;
      $display("FAIL midgrant_reset: got %h want %h", {gnt, gnt_id, gnt_valid}, own(-1));
    end
    clr = 1'b0;
    tick();
    n_checks++;
    if ({gnt, gnt_id, gnt_valid} !== own(2)) begin
      n_fail++;
      $display("FAIL after_reset_grant: got %h want %h", {gnt, gnt_id, gnt_valid}, own(2));
    end
    $display("no_preempt: owner 5 held, reset, then owner %0d", gnt_id);
  endtask

  task automatic test_timeout();
    do_reset();
    req = 32'h0000_0080;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < MAX_HOLD; i++) begin
      tick();
      n_checks++;
      if ({gnt, gnt_id, gnt_valid, timeout} !== {own(7), 1'b0}) begin
        n_fail++;
        $display("FAIL timeout_hold cyc=%0d: got %h want %h", i, {gnt, gnt_id, gnt_valid, timeout}, {own(7), 1'b0});
      end
    end
    tick();
    n_checks++;
    if ({gnt, gnt_id, gnt_valid, timeout} !== {own(-1), 1'b1}) begin
      n_fail++;
      $display("FAIL timeout_release: got %h want %h", {gnt, gnt_id, gnt_valid, timeout}, {own(-1), 1'b1});
    end
    tick();
    n_checks++;
    if ({gnt, gnt_id, gnt_valid, timeout} !== {own(7), 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_regrant: got %h want %h", {gnt, gnt_id, gnt_valid, timeout}, {own(7), 1'b0});
    end
    $display("timeout: forced release after %0d cycles, re-granted to 7", MAX_HOLD);
`else
    for (int i = 0; i < 5 * MAX_HOLD; i++) begin
      tick();
      n_checks++;
      if ({gnt, gnt_id, gnt_valid, timeout} !== {own(7), 1'b0}) begin
        n_fail++;
        $display("FAIL hold_forever cyc=%0d: got %h want %h", i, {gnt, gnt_id, gnt_valid, timeout}, {own(7), 1'b0});
      end
    end
    $display("timeout: not compiled in, owner 7 held %0d cycles", 5 * MAX_HOLD);
`endif
  endtask

  task automatic test_random();
    logic [38:0] exp;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      clr = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 2) == 0) req = $urandom & $urandom & $urandom;
      tick();
      exp = {own(m_owner), m_to};
      n_checks++;
      if ({gnt, gnt_id, gnt_valid, timeout} !== exp) begin
        n_fail++;
        $display("FAIL random cyc=%0d req=%h clr=%b: got %h want %h", c, req, clr, {gnt, gnt_id, gnt_valid, timeout}, exp);
      end
      if (gnt_valid && m_held == 1) $display("random: cyc=%0d grant id=%0d", c, gnt_id);
    end
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_no_preempt_reset();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
